// File: rtl/auto_bp_collector.sv
// Bad-pixel list collector: ping-pong banks filled per frame, published on frame_done.
// Optional `AUTO_BP_DEDUP_EN drops repeats of the last stored {x,y} in a frame.
module auto_bp_collector #(
    parameter int CNT_WIDTH   = 10,
    parameter int AUTO_BP_NUM = 256,
    parameter int AUTO_BP_BIT = 8
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   frame_start,
    input  logic                   frame_done,
    input  logic                   bp_valid,
    input  logic [CNT_WIDTH-1:0]   bp_x,
    input  logic [CNT_WIDTH-1:0]   bp_y,
    input  logic                   bp_type,
    output logic                   bp_ready,
    input  logic                   rd_en,
    input  logic [AUTO_BP_BIT-1:0] rd_addr,
    output logic                   rd_valid,
    output logic [31:0]            rd_data,
    output logic [AUTO_BP_BIT:0]   list_count,
    output logic                   list_ready,
    output logic                   overflow,
    output logic [15:0]            drop_count
);

    localparam logic [AUTO_BP_BIT:0] CAP = (AUTO_BP_BIT+1)'(AUTO_BP_NUM);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_COMMIT
    } state_t;

    state_t state, state_nxt;
    logic   clr_frame;
    logic   do_commit;
    logic   xfer;
    logic   dup;
    logic   has_room;
    logic   store;
    logic   drop;

    logic [AUTO_BP_BIT:0]   wr_cnt;
    logic                   ovf_pend;
    logic [15:0]            drop_pend;
    logic                   wr_sel;
    logic [31:0]            entry;
    logic [AUTO_BP_BIT-1:0] wr_addr;

    logic [31:0] bank0 [AUTO_BP_NUM];
    logic [31:0] bank1 [AUTO_BP_NUM];
    logic [31:0] q0, q1;
    logic        rd_hit;
    logic        rd_pub;

    always_ff @(posedge aclk) begin
        if (!aresetn)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr_frame = 1'b0;
        do_commit = 1'b0;
        bp_ready  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (frame_start) begin
                    state_nxt = ST_COLLECT;
                    clr_frame = 1'b1;
                end
            end
            ST_COLLECT: begin
                bp_ready = 1'b1;
                if (frame_done)
                    state_nxt = ST_COMMIT;
                else if (frame_start)
                    clr_frame = 1'b1;
            end
            ST_COMMIT: begin
                do_commit = 1'b1;
                if (frame_start) begin
                    state_nxt = ST_COLLECT;
                    clr_frame = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A pixel arriving with an aborting frame_start belongs to the dead frame.
    assign xfer     = bp_valid & bp_ready & ~clr_frame;
    assign has_room = (wr_cnt < CAP);
    assign store    = xfer & ~dup & has_room;
    assign drop     = xfer & ~dup & ~has_room;
    assign wr_addr  = wr_cnt[AUTO_BP_BIT-1:0];

    always_comb begin
        entry                   = '0;
        entry[31]               = bp_type;
        entry[16 +: CNT_WIDTH]  = bp_y;
        entry[0  +: CNT_WIDTH]  = bp_x;
    end

`ifdef AUTO_BP_DEDUP_EN
    logic                 last_vld;
    logic [CNT_WIDTH-1:0] last_x;
    logic [CNT_WIDTH-1:0] last_y;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            last_vld <= 1'b0;
            last_x   <= '0;
            last_y   <= '0;
        end else if (clr_frame) begin
            last_vld <= 1'b0;
        end else if (store) begin
            last_vld <= 1'b1;
            last_x   <= bp_x;
            last_y   <= bp_y;
        end
    end

    assign dup = last_vld && (bp_x == last_x) && (bp_y == last_y);
`else
    assign dup = 1'b0;
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_cnt    <= '0;
            ovf_pend  <= 1'b0;
            drop_pend <= '0;
        end else if (clr_frame) begin
            wr_cnt    <= '0;
            ovf_pend  <= 1'b0;
            drop_pend <= '0;
        end else begin
            if (store)
                wr_cnt <= wr_cnt + 1'b1;
            if (drop) begin
                ovf_pend <= 1'b1;
                if (drop_pend != 16'hFFFF)
                    drop_pend <= drop_pend + 16'd1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_sel     <= 1'b0;
            list_count <= '0;
            list_ready <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (do_commit) begin
            wr_sel     <= ~wr_sel;
            list_count <= wr_cnt;
            list_ready <= 1'b1;
            overflow   <= ovf_pend;
            drop_count <= drop_pend;
        end
    end

    // Contents are never reset; stale words are masked by rd_hit.
    always_ff @(posedge aclk) begin
        if (store && !wr_sel)
            bank0[wr_addr] <= entry;
        if (store && wr_sel)
            bank1[wr_addr] <= entry;
        q0 <= bank0[rd_addr];
        q1 <= bank1[rd_addr];
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_valid <= 1'b0;
            rd_hit   <= 1'b0;
            rd_pub   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            rd_hit   <= rd_en && list_ready &&
                        ({1'b0, rd_addr} < list_count);
            rd_pub   <= ~wr_sel;
        end
    end

    assign rd_data = rd_hit ? (rd_pub ? q1 : q0) : 32'd0;

endmodule
